shift_arbiter_16b: RTL and testbench
====================================

Name: shift_arbiter_16b

Overview:
- Sequencer and round-robin arbiter that shares one bar_shift_16b instance between two requesters, A and B.
- Latches the winning request's operand, amount, direction and sign mode, then drives the shifter for one cycle.
- Registers the result, applies out-of-range amount handling, and holds the result until the requester acknowledges it.
- Sits between the ALU issue logic (requester A) and the address/immediate unit (requester B), and the single shared barrel shifter.

Parameters:
- W, 16, data width; fixed to match the shifter. Only 16 is supported.
- SHW, 5, shift-amount width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req_a  input  1  A requests a shift (level)
- in_a  input  16  A operand
- sh_a  input  5  A shift amount, 0..31
- cont_a  input  1  A direction: 0 = left, 1 = right
- sign_a  input  1  A right-shift mode: 1 = arithmetic, 0 = logical; ignored when cont_a=0
- gnt_a  output  1  one-cycle pulse: A's request accepted
- done_a  output  1  result valid for A
- ack_a  input  1  A consumes the result
- req_b, in_b, sh_b, cont_b, sign_b, gnt_b, done_b, ack_b: identical set for requester B
- res  output  16  shift result, valid while done_a or done_b is high
- busy  output  1  high whenever state != IDLE
- bs_in  output  16  to shifter in
- bs_sh  output  5  to shifter sh
- bs_cont  output  1  to shifter cont
- bs_sign  output  1  to shifter sign
- bs_out  input  16  from shifter out (combinational)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state=IDLE; gnt_*, done_*, busy=0; res=0; bs_in, bs_sh, bs_cont, bs_sign=0; clamp=0; last=B (so A wins the first tie).
- IDLE state, at a clk edge:
  - If exactly one req is high, that requester wins.
  - If both are high, the requester not equal to last wins.
  - On a win: latch the winner's operands into bs_* and clamp, set gnt_x=1, set last to the winner, go to SHIFT.
  - If no req is high, stay in IDLE.
- SHIFT state (exactly one cycle):
  - bs_* are stable, so bs_out is valid.
  - At the edge: res <= clamp ? clampval : bs_out; done_x=1 for the granted requester; gnt_x=0; go to RESP.
- RESP state:
  - res and done_x are held unchanged until ack_x=1 is sampled.
  - On that edge: done_x=0, go to IDLE.
  - The other requester's ack is ignored. req inputs are ignored.
- Latency and throughput:
  - Request sampled at edge N. gnt_x is high during cycle N..N+1. done_x rises at edge N+1.
  - Minimum 3 cycles per operation (IDLE, SHIFT, RESP with immediate ack).
- Requester obligation: deassert req in the cycle gnt is seen. A req still high in IDLE after RESP is treated as a new request.
- Range handling, computed at latch time, with sh >= 16:
  - Left, or logical right: clamp=1, clampval=0x0000.
  - Arithmetic right: bs_sh forced to 15, clamp=0. The result is replicated sign: 0xFFFF if operand bit 15 is set, else 0x0000.
  - sh = 0..15: passed through unchanged. sh=0 returns the operand.
- bs_* hold their last latched value outside SHIFT; they change only on a grant.
- Only one of done_a and done_b is ever high. gnt_a and gnt_b are never high together.
- Reset mid-operation (any state): immediate return to reset values. An in-flight result is discarded and no done is issued.
- ack asserted while no done is pending has no effect.

Test Plan:
- Left shift: A requests in=0x00F1, sh=4, cont=0, ack tied high. gnt_a pulses next edge, done_a one cycle later, res=0x0F10; bs_cont=0, bs_sh=4 during SHIFT.
- Right shifts: B requests in=0x8000, sh=3, cont=1.
  - sign=1 gives res=0xF000.
  - Repeat with sign=0: res=0x1000.
  - done_b only; done_a stays 0.
- Out of range:
  - A left 0x1234, sh=20 gives res=0x0000.
  - Logical right 0xFFFF, sh=16 gives 0x0000.
  - Arithmetic right 0x8001, sh=20 gives 0xFFFF with bs_sh=15.
  - Arithmetic right 0x7FFF, sh=31 gives 0x0000.
- Arbitration: req_a and req_b held high continuously, ack immediate. Grants are A, B, A, B on every third cycle. After reset the first tie goes to A.
- Ack back-pressure: A result 0x0F10 with ack_a held low for 5 cycles while req_b=1. res and done_a stay stable, busy=1, no gnt_b. gnt_b is issued only after ack_a is sampled and the arbiter has returned to IDLE.
- Reset mid-SHIFT: assert rst during SHIFT. All outputs go to 0 asynchronously, no done pulse follows, and the next request is granted normally.

Source files
------------

// File: rtl/shift_arbiter_16b.sv
// shift_arbiter_16b: round-robin sequencer sharing one 16-bit barrel shifter between requesters A and B
module shift_arbiter_16b #(
   parameter int W   = 16,
   parameter int SHW = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_a,
   input  logic [W-1:0]   in_a,
   input  logic [SHW-1:0] sh_a,
   input  logic           cont_a,
   input  logic           sign_a,
   output logic           gnt_a,
   output logic           done_a,
   input  logic           ack_a,
   input  logic           req_b,
   input  logic [W-1:0]   in_b,
   input  logic [SHW-1:0] sh_b,
   input  logic           cont_b,
   input  logic           sign_b,
   output logic           gnt_b,
   output logic           done_b,
   input  logic           ack_b,
   output logic [W-1:0]   res,
   output logic           busy,
   output logic [W-1:0]   bs_in,
   output logic [SHW-1:0] bs_sh,
   output logic           bs_cont,
   output logic           bs_sign,
   input  logic [W-1:0]   bs_out
);
   typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
   state_t state, state_nx;
   logic last, clamp, win_a, win_b, ack, w_cont, w_sign, w_ar, w_big;
   logic [W-1:0] w_in;
   logic [SHW-1:0] w_sh;
   assign busy = state != IDLE;
   // winner selection (last=1 means B was served last) and next-state
   always_comb begin
      win_a = req_a & (~req_b | last);
      win_b = req_b & (~req_a | ~last);
      w_in = win_a ? in_a : in_b;
      w_sh = win_a ? sh_a : sh_b;
      w_cont = win_a ? cont_a : cont_b;
      w_sign = win_a ? sign_a : sign_b;
      w_ar = w_cont & w_sign;
      w_big = w_sh >= SHW'(W);
      ack = last ? ack_b : ack_a;
      state_nx = state == IDLE ? ((win_a | win_b) ? SHIFT : IDLE) :
                 state == SHIFT ? RESP : (ack ? IDLE : RESP);
   end
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   // latch winner operands, capture shifter result, hold until acknowledged
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         gnt_a <= 1'b0;
         gnt_b <= 1'b0;
         done_a <= 1'b0;
         done_b <= 1'b0;
         res <= '0;
         bs_in <= '0;
         bs_sh <= '0;
         bs_cont <= 1'b0;
         bs_sign <= 1'b0;
         clamp <= 1'b0;
         last <= 1'b1;
      end else
         case (state)
            IDLE: if (win_a | win_b) begin
               bs_in <= w_in;
               bs_sh <= (w_big & w_ar) ? SHW'(W - 1) : w_sh;
               bs_cont <= w_cont;
               bs_sign <= w_sign;
               clamp <= w_big & ~w_ar;
               gnt_a <= win_a;
               gnt_b <= win_b;
               last <= win_b;
            end
            SHIFT: begin
               res <= clamp ? '0 : bs_out;
               done_a <= ~last;
               done_b <= last;
               gnt_a <= 1'b0;
               gnt_b <= 1'b0;
            end
            RESP: if (ack) begin
               done_a <= 1'b0;
               done_b <= 1'b0;
            end
            default: ;
         endcase
endmodule

// File: tb/tb_shift_arbiter_16b.sv
// tb_shift_arbiter_16b: scoreboard bench for the shared-shifter arbiter with a behavioural barrel shifter
module tb_shift_arbiter_16b;
   logic clk = 0, rst = 1;
   logic req_a = 0, cont_a = 0, sign_a = 0, ack_a = 1, gnt_a, done_a;
   logic req_b = 0, cont_b = 0, sign_b = 0, ack_b = 1, gnt_b, done_b;
   logic [15:0] in_a = 0, in_b = 0, res, bs_in, bs_out;
   logic [4:0] sh_a = 0, sh_b = 0, bs_sh;
   logic bs_cont, bs_sign, busy;
   logic signed [15:0] bs_sin;
   typedef struct packed {logic who; logic [15:0] res;} exp_t;
   exp_t sb[$];
   exp_t e;
   int n_cmp = 0, n_bad = 0, ngnt, ndone, lastc;

   shift_arbiter_16b dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .in_a(in_a), .sh_a(sh_a), .cont_a(cont_a), .sign_a(sign_a),
      .gnt_a(gnt_a), .done_a(done_a), .ack_a(ack_a),
      .req_b(req_b), .in_b(in_b), .sh_b(sh_b), .cont_b(cont_b), .sign_b(sign_b),
      .gnt_b(gnt_b), .done_b(done_b), .ack_b(ack_b),
      .res(res), .busy(busy), .bs_in(bs_in), .bs_sh(bs_sh),
      .bs_cont(bs_cont), .bs_sign(bs_sign), .bs_out(bs_out)
   );

   always #5 clk = ~clk;
   assign bs_sin = $signed(bs_in) >>> bs_sh;
   assign bs_out = bs_cont ? (bs_sign ? bs_sin : bs_in >> bs_sh) : bs_in << bs_sh;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] d, input logic [4:0] s, input logic c, input logic g);
      logic signed [15:0] sd;
      sd = d;
      if (s >= 5'd16) return (c && g) ? {16{d[15]}} : 16'h0000;
      if (!c) return d << s;
      if (!g) return d >> s;
      sd = sd >>> s;
      return sd;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst = 1;
      req_a = 0;
      req_b = 0;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic drive(input logic who, input logic [15:0] d, input logic [4:0] s, input logic c, input logic g);
      if (who) begin
         req_b = 1; in_b = d; sh_b = s; cont_b = c; sign_b = g;
      end else begin
         req_a = 1; in_a = d; sh_a = s; cont_a = c; sign_a = g;
      end
   endtask

   task automatic wait_gnt(input logic who);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(who ? gnt_b : gnt_a) && n < 10);
      check("gnt", who ? gnt_b : gnt_a, 1);
      check("gnt_other", who ? gnt_a : gnt_b, 0);
   endtask

   task automatic do_op(input logic who, input logic [15:0] d, input logic [4:0] s, input logic c, input logic g);
      logic [4:0] esh;
      exp_t x;
      sb.push_back({who, model(d, s, c, g)});
      esh = (s >= 5'd16 && c && g) ? 5'd15 : s;
      @(posedge clk);
      #1;
      drive(who, d, s, c, g);
      wait_gnt(who);
      check("bs_sh", bs_sh, esh);
      check("bs_cont", bs_cont, c);
      check("bs_in", bs_in, d);
      req_a = 0;
      req_b = 0;
      @(negedge clk);
      x = sb.pop_front();
      check("done", x.who ? done_b : done_a, 1);
      check("done_other", x.who ? done_a : done_b, 0);
      check("res", res, x.res);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_gnt", {gnt_a, gnt_b}, 0);
      check("rst_done", {done_a, done_b}, 0);
      check("rst_res", res, 0);
      check("rst_bs", {bs_in, bs_sh, bs_cont, bs_sign}, 0);
      rst = 0;
      do_op(0, 16'h00F1, 5'd4, 0, 0);
      do_op(1, 16'h8000, 5'd3, 1, 1);
      do_op(1, 16'h8000, 5'd3, 1, 0);
      do_op(0, 16'h1234, 5'd20, 0, 0);
      do_op(0, 16'hFFFF, 5'd16, 1, 0);
      do_op(0, 16'h8001, 5'd20, 1, 1);
      do_op(0, 16'h7FFF, 5'd31, 1, 1);
      do_op(1, 16'hABCD, 5'd0, 1, 1);
      for (int i = 0; i < 8; i++)
         do_op(1'($urandom_range(1)), 16'($urandom), 5'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
      // both requesters held high: alternating grants every third cycle, A first after reset
      apply_reset();
      @(posedge clk);
      #1;
      drive(0, 16'h0001, 5'd1, 0, 0);
      drive(1, 16'h0100, 5'd4, 1, 0);
      for (int i = 0; i < 4; i++) sb.push_back({i[0], i[0] ? 16'h0010 : 16'h0002});
      ngnt = 0;
      ndone = 0;
      lastc = 0;
      for (int c = 1; c <= 20 && ndone < 4; c++) begin
         @(negedge clk);
         if (gnt_a | gnt_b) begin
            check("arb_excl", gnt_a & gnt_b, 0);
            check("arb_order", gnt_b, ngnt % 2);
            if (ngnt > 0) check("arb_gap", c - lastc, 3);
            lastc = c;
            ngnt++;
         end
         if (done_a | done_b) begin
            e = sb.pop_front();
            check("arb_done_excl", done_a & done_b, 0);
            check("arb_done_who", done_b, e.who);
            check("arb_res", res, e.res);
            ndone++;
         end
      end
      req_a = 0;
      req_b = 0;
      check("arb_count", ndone, 4);
      // back-pressure: A holds its result while B waits
      ack_a = 0;
      @(posedge clk);
      #1;
      drive(0, 16'h00F1, 5'd4, 0, 0);
      drive(1, 16'h0003, 5'd1, 0, 0);
      sb.push_back({1'b0, 16'h0F10});
      sb.push_back({1'b1, 16'h0006});
      wait_gnt(0);
      req_a = 0;
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_res", res, e.res);
         check("bp_done", {done_a, done_b}, 2'b10);
         check("bp_busy", busy, 1);
         check("bp_gnt_b", gnt_b, 0);
      end
      ack_a = 1;
      @(negedge clk);
      check("bp_release", {done_a, gnt_b, busy}, 0);
      @(negedge clk);
      check("bp_gnt_b_late", gnt_b, 1);
      req_b = 0;
      @(negedge clk);
      e = sb.pop_front();
      check("bp_done_b", {done_a, done_b}, 2'b01);
      check("bp_res_b", res, e.res);
      // reset in SHIFT discards the operation
      @(posedge clk);
      #1;
      drive(0, 16'h00F1, 5'd4, 0, 0);
      wait_gnt(0);
      rst = 1;
      #1;
      check("mid_rst_ctl", {gnt_a, gnt_b, done_a, done_b, busy}, 0);
      check("mid_rst_res", res, 0);
      check("mid_rst_bs", {bs_in, bs_sh, bs_cont, bs_sign}, 0);
      req_a = 0;
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("mid_rst_nodone", {done_a, done_b}, 0);
      end
      do_op(0, 16'h1234, 5'd8, 1, 0);
      do_op(1, 16'hC000, 5'd1, 1, 1);
      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
